elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
//   Single-car sweep scheduler. Floor calls are latched into a pending set.
//   The car keeps moving in its current direction while requests remain
//   ahead of it. It stops to open the door at every pending floor it reaches,
//   and turns around only when nothing is left ahead.
//
// Parameters
//   FLOORS       number of floors (2..8)
//   DOOR_CYCLES  door-open dwell in clk cycles (>= 1)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   call_req   level requests, bit i asks for service at floor i
//   arrive     one-cycle pulse from the car: adjacent floor reached
//   move_up    command car up one floor, held until arrive
//   move_down  command car down one floor, held until arrive
//   door_open  door open at cur_floor
//   cur_floor  current car floor, binary
//   pending    latched outstanding requests
//   dir_up     sweep direction, 1 = up
//   busy       high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module elevator_scheduler #(
  parameter int FLOORS      = 5,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_req,
  input  logic              arrive,
  output logic              move_up,
  output logic              move_down,
  output logic              door_open,
  output logic [2:0]        cur_floor,
  output logic [FLOORS-1:0] pending,
  output logic              dir_up,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  localparam int CW = $clog2(DOOR_CYCLES + 1);

  state_t            state, state_n;
  logic [2:0]        floor_n;
  logic              dir_n;
  logic [CW-1:0]     cnt, cnt_n;

  // Floor masks relative to the current floor. They are built by comparison
  // rather than by indexing, so the 3-bit floor number never has to match
  // the width of the request vector.
  logic [FLOORS-1:0] cur_m, up_m, dn_m, above_m, below_m, clr_m;
  logic              above, below, at_top, at_bottom;

  always_comb begin
    for (int i = 0; i < FLOORS; i++) begin
      cur_m[i]   = (i == int'(cur_floor));
      up_m[i]    = (i == int'(cur_floor) + 1);
      dn_m[i]    = (i + 1 == int'(cur_floor));
      above_m[i] = (i > int'(cur_floor));
      below_m[i] = (i < int'(cur_floor));
    end
  end

  assign above     = |(pending & above_m);
  assign below     = |(pending & below_m);
  assign at_top    = (int'(cur_floor) == FLOORS - 1);
  assign at_bottom = (cur_floor == 3'd0);

  // Next-state decision.
  // NOTE: every signal is given a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    floor_n = cur_floor;
    dir_n   = dir_up;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (|(pending & cur_m)) begin
          state_n = DOOR;
          cnt_n   = CW'(DOOR_CYCLES);
        end else if (above && below) begin
          state_n = dir_up ? UP : DOWN;
        end else if (above) begin
          state_n = UP;
          dir_n   = 1'b1;
        end else if (below) begin
          state_n = DOWN;
          dir_n   = 1'b0;
        end
      end
      UP: begin
        if (arrive) begin
          if (at_top) begin
            // A spurious arrive at the end of the shaft must not wrap the floor.
            state_n = IDLE;
          end else begin
            floor_n = cur_floor + 3'd1;
            if (|(pending & up_m)) begin
              state_n = DOOR;
              cnt_n   = CW'(DOOR_CYCLES);
            end
          end
        end
      end
      DOWN: begin
        if (arrive) begin
          if (at_bottom) begin
            state_n = IDLE;
          end else begin
            floor_n = cur_floor - 3'd1;
            if (|(pending & dn_m)) begin
              state_n = DOOR;
              cnt_n   = CW'(DOOR_CYCLES);
            end
          end
        end
      end
      DOOR: begin
        if (cnt <= CW'(1)) begin
          cnt_n = '0;
          // Prefer to continue the current sweep; reverse only when nothing
          // is left ahead.
          if (dir_up) begin
            if (above) begin
              state_n = UP;
            end else if (below) begin
              state_n = DOWN;
              dir_n   = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            if (below) begin
              state_n = DOWN;
            end else if (above) begin
              state_n = UP;
              dir_n   = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The request at the door floor is cleared on the entry edge, throughout
  // the dwell, and on the expiry edge. A call held for the whole dwell
  // therefore does not reopen the door.
  always_comb begin
    for (int i = 0; i < FLOORS; i++) begin
      clr_m[i] = (i == int'(floor_n)) && ((state == DOOR) || (state_n == DOOR));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_floor <= 3'd0;
      pending   <= '0;
      dir_up    <= 1'b1;
      cnt       <= '0;
      move_up   <= 1'b0;
      move_down <= 1'b0;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_floor <= floor_n;
      pending   <= (pending | call_req) & ~clr_m;
      dir_up    <= dir_n;
      cnt       <= cnt_n;
      move_up   <= (state_n == UP);
      move_down <= (state_n == DOWN);
      door_open <= (state_n == DOOR);
      busy      <= (state_n != IDLE);
    end
  end

endmodule
